// File: rtl/pool_rf_ctrl_if.sv
// Stream and register-file bundle for the 2x2 max-pooling sequencer.
// master: the sequencer (drives in_ready, rf_*, out_*); slave: its surroundings.
interface pool_rf_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pix0;
    logic [DATA_W-1:0] in_pix1;
    logic              rf_wr1;
    logic              rf_wr2;
    logic [DATA_W-1:0] rf_in1;
    logic [DATA_W-1:0] rf_in2;
    logic [ADDR_W-1:0] rf_adrs_in1;
    logic [ADDR_W-1:0] rf_adrs_in2;
    logic [ADDR_W-1:0] rf_adrs_out;
    logic [DATA_W-1:0] rf_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              tile_done;

    modport master (
        input  in_valid, in_pix0, in_pix1, rf_out, out_ready,
        output in_ready, rf_wr1, rf_wr2, rf_in1, rf_in2,
        output rf_adrs_in1, rf_adrs_in2, rf_adrs_out,
        output out_valid, out_data, tile_done
    );

    modport slave (
        output in_valid, in_pix0, in_pix1, rf_out, out_ready,
        input  in_ready, rf_wr1, rf_wr2, rf_in1, rf_in2,
        input  rf_adrs_in1, rf_adrs_in2, rf_adrs_out,
        input  out_valid, out_data, tile_done
    );
endinterface

// File: rtl/pool_rf_ctrl.sv
// 2x2 max-pooling sequencer: fills a 4x4 tile into the register file, then
// reads each 2x2 window and streams its maximum. Ports: clk, nrst, flush, bus.
module pool_rf_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int SIGNED_CMP = 1
) (
    input  logic clk,
    input  logic nrst,
    input  logic flush,
    pool_rf_ctrl_if.master bus
);
    typedef enum logic [1:0] {FILL, DRAIN, EMIT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    logic [1:0]        win_q, win_d;
    logic [2:0]        rd_q, rd_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              in_fire;
    logic              out_fire;
    logic              gt;

    assign bus.in_ready    = (state_q == FILL);
    assign in_fire         = bus.in_valid & bus.in_ready & ~flush;
    assign bus.rf_wr1      = in_fire;
    assign bus.rf_wr2      = in_fire;
    assign bus.rf_in1      = bus.in_pix0;
    assign bus.rf_in2      = bus.in_pix1;
    assign bus.rf_adrs_in1 = ADDR_W'({beat_q, 1'b0});
    assign bus.rf_adrs_in2 = ADDR_W'({beat_q, 1'b1});

    // Window base sits on bits 3/1, the in-window offset (+1, +4) on bits 2/0.
    assign bus.rf_adrs_out = (state_q == DRAIN && rd_q < 3'd4)
                           ? ADDR_W'({win_q[1], rd_q[1], win_q[0], rd_q[0]})
                           : '0;

    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_data  = max_q;
    assign out_fire      = bus.out_valid & bus.out_ready & ~flush;
    assign bus.tile_done = out_fire & (win_q == 2'd3);

    always_comb begin
        gt = 1'b0;
        if (SIGNED_CMP != 0)
            gt = $signed(bus.rf_out) > $signed(max_q);
        else
            gt = bus.rf_out > max_q;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        win_d   = win_q;
        rd_d    = rd_q;
        max_d   = max_q;
        unique case (state_q)
            FILL: begin
                if (in_fire) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = DRAIN;
                        win_d   = 2'd0;
                        rd_d    = 3'd0;
                    end
                end
            end
            DRAIN: begin
                rd_d = rd_q + 3'd1;
                // Read data lags the address by one cycle.
                if (rd_q == 3'd1)
                    max_d = bus.rf_out;
                else if (rd_q >= 3'd2 && gt)
                    max_d = bus.rf_out;
                if (rd_q == 3'd4) begin
                    state_d = EMIT;
                    rd_d    = 3'd0;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    rd_d = 3'd0;
                    if (win_q == 2'd3) begin
                        state_d = FILL;
                        beat_d  = 3'd0;
                        win_d   = 2'd0;
                    end else begin
                        state_d = DRAIN;
                        win_d   = win_q + 2'd1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
        if (flush) begin
            state_d = FILL;
            beat_d  = 3'd0;
            win_d   = 2'd0;
            rd_d    = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= FILL;
            beat_q  <= 3'd0;
            win_q   <= 2'd0;
            rd_q    <= 3'd0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            win_q   <= win_d;
            rd_q    <= rd_d;
            max_q   <= max_d;
        end
    end
endmodule

// File: tb/tb_pool_rf_ctrl.sv
// Bench for pool_rf_ctrl: signed and unsigned instances share the stimulus,
// each with its own register-file model; a pooled-max model feeds the checker.
module tb_pool_rf_ctrl;
    logic        clk;
    logic        nrst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_pix0;
    logic [15:0] in_pix1;
    int          cur_pair;

    int total = 0;
    int bad = 0;

    pool_rf_ctrl_if #(.DATA_W(16), .ADDR_W(4)) if_s ();
    pool_rf_ctrl_if #(.DATA_W(16), .ADDR_W(4)) if_u ();

    pool_rf_ctrl #(.DATA_W(16), .ADDR_W(4), .SIGNED_CMP(1)) dut_s (
        .clk(clk), .nrst(nrst), .flush(flush), .bus(if_s.master)
    );
    pool_rf_ctrl #(.DATA_W(16), .ADDR_W(4), .SIGNED_CMP(0)) dut_u (
        .clk(clk), .nrst(nrst), .flush(flush), .bus(if_u.master)
    );

    assign if_s.in_valid  = in_valid;
    assign if_s.in_pix0   = in_pix0;
    assign if_s.in_pix1   = in_pix1;
    assign if_s.out_ready = out_ready;
    assign if_u.in_valid  = in_valid;
    assign if_u.in_pix0   = in_pix0;
    assign if_u.in_pix1   = in_pix1;
    assign if_u.out_ready = out_ready;

    // Register-file models: two write ports, registered read.
    logic [15:0] mem_s [16];
    logic [15:0] mem_u [16];
    always @(posedge clk) begin
        if (if_s.rf_wr1) mem_s[if_s.rf_adrs_in1] <= if_s.rf_in1;
        if (if_s.rf_wr2) mem_s[if_s.rf_adrs_in2] <= if_s.rf_in2;
        if_s.rf_out <= mem_s[if_s.rf_adrs_out];
        if (if_u.rf_wr1) mem_u[if_u.rf_adrs_in1] <= if_u.rf_in1;
        if (if_u.rf_wr2) mem_u[if_u.rf_adrs_in2] <= if_u.rf_in2;
        if_u.rf_out <= mem_u[if_u.rf_adrs_out];
    end

    logic        ov [2];
    logic        ir [2];
    logic        td [2];
    logic        w1 [2];
    logic        w2 [2];
    logic [15:0] od [2];
    logic [15:0] d1 [2];
    logic [15:0] d2 [2];
    logic [3:0]  a1 [2];
    logic [3:0]  a2 [2];
    assign ov[0] = if_s.out_valid;   assign ov[1] = if_u.out_valid;
    assign ir[0] = if_s.in_ready;    assign ir[1] = if_u.in_ready;
    assign td[0] = if_s.tile_done;   assign td[1] = if_u.tile_done;
    assign w1[0] = if_s.rf_wr1;      assign w1[1] = if_u.rf_wr1;
    assign w2[0] = if_s.rf_wr2;      assign w2[1] = if_u.rf_wr2;
    assign od[0] = if_s.out_data;    assign od[1] = if_u.out_data;
    assign d1[0] = if_s.rf_in1;      assign d1[1] = if_u.rf_in1;
    assign d2[0] = if_s.rf_in2;      assign d2[1] = if_u.rf_in2;
    assign a1[0] = if_s.rf_adrs_in1; assign a1[1] = if_u.rf_adrs_in1;
    assign a2[0] = if_s.rf_adrs_in2; assign a2[1] = if_u.rf_adrs_in2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: current tile as a row-major 4x4 image; window w covers
    // rows 2*(w/2)..+1, cols 2*(w%2)..+1.
    logic [15:0] tile [16];

    function automatic logic [15:0] pool_max(input int w, input bit sgn);
        int r0;
        int c0;
        logic [15:0] m;
        logic [15:0] v;
        r0 = (w / 2) * 2;
        c0 = (w % 2) * 2;
        m = tile[r0 * 4 + c0];
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                v = tile[(r0 + dr) * 4 + c0 + dc];
                if (sgn ? ($signed(v) > $signed(m)) : (v > m)) m = v;
            end
        return m;
    endfunction

    logic [15:0] exp_d [2][128];
    bit          exp_l [2][128];
    int          wr_idx [2];
    int          rd_idx [2];
    bit          hold_v [2];
    logic [15:0] hold_d [2];
    int          tdone_cnt [2];
    int          wr_count;

    initial begin
        for (int k = 0; k < 2; k++) begin
            wr_idx[k] = 0;
        end
    end

    // Checker: every cycle, outputs and write port against the model.
    always @(negedge clk) begin
        if (!nrst) begin
            for (int k = 0; k < 2; k++) begin
                rd_idx[k] = wr_idx[k];
                hold_v[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (hold_v[k])
                    chk(ov[k] && od[k] == hold_d[k], "hold", {15'd0, ov[k], od[k]}, {16'd1, hold_d[k]});
                if (ov[k] && out_ready) begin
                    if (rd_idx[k] == wr_idx[k]) begin
                        chk(1'b0, "extra_out", {16'd0, od[k]}, 32'd0);
                    end else begin
                        chk(od[k] == exp_d[k][rd_idx[k]], "out_data", {16'd0, od[k]}, {16'd0, exp_d[k][rd_idx[k]]});
                        chk(td[k] == exp_l[k][rd_idx[k]], "tile_done", {31'd0, td[k]}, {31'd0, exp_l[k][rd_idx[k]]});
                        rd_idx[k]++;
                    end
                    if (td[k]) tdone_cnt[k]++;
                end else begin
                    chk(td[k] == 1'b0, "tile_done_idle", {31'd0, td[k]}, 32'd0);
                end
                hold_v[k] = ov[k] && !out_ready;
                hold_d[k] = od[k];
                if (ov[k])
                    chk(ir[k] == 1'b0, "in_ready_emit", {31'd0, ir[k]}, 32'd0);
                if (in_valid && ir[k] && !flush) begin
                    chk(w1[k] && w2[k], "wr_en", {30'd0, w1[k], w2[k]}, 32'd3);
                    chk(a1[k] == 4'(2 * cur_pair) && a2[k] == 4'(2 * cur_pair + 1),
                        "wr_adr", {24'd0, a1[k], a2[k]}, 32'(2 * cur_pair));
                    chk(d1[k] == in_pix0 && d2[k] == in_pix1, "wr_data",
                        {d1[k], d2[k]}, {in_pix0, in_pix1});
                end else begin
                    chk(!w1[k] && !w2[k], "wr_idle", {30'd0, w1[k], w2[k]}, 32'd0);
                end
            end
            if (w1[0]) wr_count++;
        end
    end

    task automatic push_tile();
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 4; w++) begin
                exp_d[k][wr_idx[k]] = pool_max(w, k == 0);
                exp_l[k][wr_idx[k]] = (w == 3);
                wr_idx[k]++;
            end
    endtask

    task automatic beat(input int p);
        int n;
        in_valid = 1'b1;
        in_pix0 = tile[2 * p];
        in_pix1 = tile[2 * p + 1];
        cur_pair = p;
        n = 0;
        @(negedge clk);
        while (!ir[0] && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) chk(1'b0, "in_timeout", 32'(n), 32'd300);
        @(posedge clk);
        #1;
    endtask

    task automatic send_tile(input bit gap);
        push_tile();
        for (int p = 0; p < 8; p++) begin
            beat(p);
            if (gap) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((rd_idx[0] != wr_idx[0] || rd_idx[1] != wr_idx[1]) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk(1'b0, "out_timeout", 32'(rd_idx[0]), 32'(wr_idx[0]));
        @(posedge clk);
        #1;
    endtask

    task automatic ramp(input int base);
        for (int i = 0; i < 16; i++) tile[i] = 16'(base + i);
    endtask

    initial begin
        int n;
        int wc0;
        int td0;
        nrst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_pix0 = '0;
        in_pix1 = '0;
        cur_pair = 0;
        wr_count = 0;
        tdone_cnt[0] = 0;
        tdone_cnt[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk(if_s.out_valid == 1'b0, "rst_out_valid", {31'd0, if_s.out_valid}, 32'd0);
        chk(if_s.in_ready == 1'b1, "rst_in_ready", {31'd0, if_s.in_ready}, 32'd1);
        chk(if_s.rf_adrs_out == 4'd0, "rst_adrs_out", {28'd0, if_s.rf_adrs_out}, 32'd0);
        chk(if_s.out_data == 16'd0, "rst_out_data", {16'd0, if_s.out_data}, 32'd0);
        chk(if_s.tile_done == 1'b0, "rst_tile_done", {31'd0, if_s.tile_done}, 32'd0);
        nrst = 1'b1;

        // Ramp tile, with latency and write-count checks.
        ramp(0);
        chk(pool_max(0, 1) == 16'd5, "model_w0", {16'd0, pool_max(0, 1)}, 32'd5);
        chk(pool_max(3, 0) == 16'd15, "model_w3", {16'd0, pool_max(3, 0)}, 32'd15);
        wc0 = wr_count;
        td0 = tdone_cnt[0];
        send_tile(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_s.out_valid && n < 20);
        chk(n == 6, "latency", 32'(n), 32'd6);
        wait_done();
        chk(wr_count - wc0 == 8, "write_cycles", 32'(wr_count - wc0), 32'd8);
        chk(tdone_cnt[0] - td0 == 1, "tile_done_cnt1", 32'(tdone_cnt[0] - td0), 32'd1);

        // Negative window, 0x8000 elsewhere.
        for (int i = 0; i < 16; i++) tile[i] = 16'h8000;
        tile[0] = 16'hFFFD; tile[1] = 16'hFFFF;
        tile[4] = 16'hFFF9; tile[5] = 16'hFFFE;
        chk(pool_max(0, 1) == 16'hFFFF, "model_neg_s", {16'd0, pool_max(0, 1)}, 32'hFFFF);
        chk(pool_max(0, 0) == 16'hFFFF, "model_neg_u", {16'd0, pool_max(0, 0)}, 32'hFFFF);
        send_tile(1'b0);
        wait_done();

        // Values whose ordering differs between signed and unsigned compare.
        for (int i = 0; i < 16; i++) tile[i] = 16'h8000;
        tile[1] = 16'h7FFF;
        tile[2] = 16'hFFFF; tile[3] = 16'h0001;
        tile[6] = 16'hFFFF; tile[7] = 16'hFFFF;
        chk(pool_max(0, 1) == 16'h7FFF, "model_mix_s0", {16'd0, pool_max(0, 1)}, 32'h7FFF);
        chk(pool_max(0, 0) == 16'h8000, "model_mix_u0", {16'd0, pool_max(0, 0)}, 32'h8000);
        chk(pool_max(1, 1) == 16'h0001, "model_mix_s1", {16'd0, pool_max(1, 1)}, 32'h0001);
        send_tile(1'b0);
        wait_done();

        // Backpressure on the first result.
        ramp(0);
        out_ready = 1'b0;
        send_tile(1'b0);
        n = 0;
        while (!if_s.out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk(1'b0, "bp_timeout", 32'(n), 32'd50);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk(if_s.out_valid == 1'b1, "bp_valid", {31'd0, if_s.out_valid}, 32'd1);
            chk(if_s.out_data == 16'd5, "bp_data", {16'd0, if_s.out_data}, 32'd5);
            chk(if_s.in_ready == 1'b0, "bp_in_ready", {31'd0, if_s.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done();

        // Gapped input.
        ramp(0);
        send_tile(1'b1);
        wait_done();

        // Flush after five beats, with a beat presented in the flush cycle.
        ramp(200);
        for (int p = 0; p < 5; p++) beat(p);
        flush = 1'b1;
        in_valid = 1'b1;
        in_pix0 = 16'hDEAD;
        in_pix1 = 16'hBEEF;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        ramp(100);
        send_tile(1'b0);
        wait_done();

        // Two tiles back to back.
        td0 = tdone_cnt[0];
        ramp(0);
        send_tile(1'b0);
        ramp(16);
        send_tile(1'b0);
        wait_done();
        chk(tdone_cnt[0] - td0 == 2, "tile_done_cnt2", 32'(tdone_cnt[0] - td0), 32'd2);

        // Reset in the middle of DRAIN, then a clean tile.
        ramp(0);
        send_tile(1'b0);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        chk(if_s.out_valid == 1'b0, "rstmid_out_valid", {31'd0, if_s.out_valid}, 32'd0);
        chk(if_s.in_ready == 1'b1, "rstmid_in_ready", {31'd0, if_s.in_ready}, 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        ramp(100);
        send_tile(1'b0);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
